// File: rtl/ldpc_cn_minacc.sv
// LDPC check-node min-finder: folds saturated per-lane A+/-B beats into min1/min2/idx1 per frame.
// Handshake: a beat or result transfers only on a rising edge where valid & ready are both 1.
`timescale 1ns/1ps
module ldpc_cn_minacc #(
  parameter int Q       = 8,
  parameter int SIMD    = 4,
  parameter int MAX_DEG = 16,
  parameter int SAT_MAX = 63,
  localparam int IW     = $clog2(MAX_DEG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Q*SIMD-1:0]   in_a_i,
  input  logic [Q*SIMD-1:0]   in_b_i,
  input  logic                in_sub_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Q*SIMD-1:0]   min1_o,
  output logic [Q*SIMD-1:0]   min2_o,
  output logic [IW*SIMD-1:0]  idx1_o,
  output logic [IW:0]         deg_o,
  output logic                err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  localparam logic signed [Q:0]   SAT_HI   = (Q+1)'(SAT_MAX);
  localparam logic signed [Q:0]   SAT_LO   = (Q+1)'(-SAT_MAX);
  localparam logic signed [Q-1:0] SAT_Q    = Q'(SAT_MAX);
  localparam logic [IW:0]         LAST_IDX = (IW+1)'(MAX_DEG-1);

  // state_q is the observable FSM state for bound checkers
  state_t state_q, state_d;

  logic signed [Q-1:0] sat_v  [SIMD];
  logic signed [Q-1:0] min1_q [SIMD];
  logic signed [Q-1:0] min2_q [SIMD];
  logic [IW-1:0]       idx1_q [SIMD];
  logic [IW:0]         cnt_q;
  logic                err_q;

  logic accept, close_beat, out_fire;

  assign in_ready_o  = (state_q != S_OUT);
  assign out_valid_o = (state_q == S_OUT);
  assign accept      = in_valid_i & in_ready_o;
  assign close_beat  = accept & (in_last_i | (cnt_q == LAST_IDX));
  assign out_fire    = out_valid_o & out_ready_i;

  // One extra bit of headroom keeps A+/-B exact before clamping
  always_comb begin : sat_calc
    logic signed [Q:0] a_x, b_x, v;
    a_x = '0;
    b_x = '0;
    v   = '0;
    for (int i = 0; i < SIMD; i++) begin
      a_x = $signed({in_a_i[i*Q+Q-1], in_a_i[i*Q +: Q]});
      b_x = $signed({in_b_i[i*Q+Q-1], in_b_i[i*Q +: Q]});
      v   = in_sub_i ? (a_x - b_x) : (a_x + b_x);
      if (v > SAT_HI)      sat_v[i] = SAT_Q;
      else if (v < SAT_LO) sat_v[i] = -SAT_Q;
      else                 sat_v[i] = v[Q-1:0];
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACC: if (accept) state_d = close_beat ? S_OUT : S_ACC;
      S_OUT:         if (out_ready_i) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Accumulators double as result registers; they are re-armed when the result is taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < SIMD; i++) begin
        min1_q[i] <= SAT_Q;
        min2_q[i] <= SAT_Q;
        idx1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (out_fire) begin
        cnt_q <= '0;
        err_q <= 1'b0;
        for (int i = 0; i < SIMD; i++) begin
          min1_q[i] <= SAT_Q;
          min2_q[i] <= SAT_Q;
          idx1_q[i] <= '0;
        end
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (close_beat) err_q <= ~in_last_i;
        for (int i = 0; i < SIMD; i++) begin
          if (sat_v[i] < min1_q[i]) begin
            min2_q[i] <= min1_q[i];
            min1_q[i] <= sat_v[i];
            idx1_q[i] <= cnt_q[IW-1:0];
          end else if (sat_v[i] < min2_q[i]) begin
            min2_q[i] <= sat_v[i];
          end
        end
      end
    end
  end

  always_comb begin : pack_out
    min1_o = '0;
    min2_o = '0;
    idx1_o = '0;
    for (int i = 0; i < SIMD; i++) begin
      min1_o[i*Q +: Q]   = min1_q[i];
      min2_o[i*Q +: Q]   = min2_q[i];
      idx1_o[i*IW +: IW] = idx1_q[i];
    end
  end

  assign deg_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_ldpc_cn_minacc.sv
// Bench for ldpc_cn_minacc: directed frames plus random frames, results checked against a reference model queue.
`timescale 1ns/1ps
module tb_ldpc_cn_minacc;
  localparam int Q = 8, SIMD = 4, MAX_DEG = 16, SAT = 63, IW = 4;
  localparam int W = 2*Q*SIMD + IW*SIMD + IW + 2;

  logic                clk, rst;
  logic                in_valid, in_ready, in_sub, in_last;
  logic [Q*SIMD-1:0]   in_a, in_b;
  logic                out_valid, out_ready;
  logic [Q*SIMD-1:0]   min1_o, min2_o;
  logic [IW*SIMD-1:0]  idx1_o;
  logic [IW:0]         deg_o;
  logic                err_o;

  ldpc_cn_minacc #(.Q(Q), .SIMD(SIMD), .MAX_DEG(MAX_DEG), .SAT_MAX(SAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_sub_i(in_sub), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .min1_o(min1_o), .min2_o(min2_o), .idx1_o(idx1_o), .deg_o(deg_o), .err_o(err_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int m1[SIMD], m2[SIMD], mi[SIMD];
  int mcnt;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes4(input int x0, input int x1, input int x2, input int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [W-1:0] obs_pack();
    return {min1_o, min2_o, idx1_o, deg_o, err_o};
  endfunction

  // reference model
  task automatic model_clear();
    for (int i = 0; i < SIMD; i++) begin
      m1[i] = SAT; m2[i] = SAT; mi[i] = 0;
    end
    mcnt = 0;
  endtask

  function automatic logic [W-1:0] model_pack(input logic err);
    logic [Q*SIMD-1:0]  e1, e2;
    logic [IW*SIMD-1:0] ei;
    for (int i = 0; i < SIMD; i++) begin
      e1[i*Q +: Q]   = Q'(m1[i]);
      e2[i*Q +: Q]   = Q'(m2[i]);
      ei[i*IW +: IW] = IW'(mi[i]);
    end
    return {e1, e2, ei, (IW+1)'(mcnt), err};
  endfunction

  task automatic model_fold(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int av, bv, v;
    for (int i = 0; i < SIMD; i++) begin
      av = $signed(a[i*Q +: Q]);
      bv = $signed(b[i*Q +: Q]);
      v  = sub ? av - bv : av + bv;
      if (v > SAT) v = SAT;
      else if (v < -SAT) v = -SAT;
      if (v < m1[i]) begin
        m2[i] = m1[i]; m1[i] = v; mi[i] = mcnt;
      end else if (v < m2[i]) begin
        m2[i] = v;
      end
    end
    mcnt++;
  endtask

  // driver tasks (entered and left on a falling edge)
  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_outputs", obs_pack(), model_pack(1'b0));
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic last, input int gap, output bit closed);
    int w;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom;
      in_sub = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_a = a; in_b = b; in_sub = sub; in_last = last; in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w == 40) begin
      check("in_ready_timeout", W'(in_ready), W'(1));
      in_valid = 1'b0;
      closed = 1'b1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    model_fold(a, b, sub);
    closed = last || (mcnt == MAX_DEG);
    if (closed) begin
      exp_q.push_back(model_pack(!last));
      model_clear();
      check("latency_out_valid", W'(out_valid), W'(1));
      check("out_blocks_input", W'(in_ready), W'(0));
    end else begin
      check("no_early_valid", W'(out_valid), W'(0));
    end
  endtask

  task automatic wait_result();
    int w;
    w = 0;
    while (out_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("out_valid_timeout", W'(out_valid), W'(1));
    check("queue_nonempty", W'(exp_q.size() != 0), W'(1));
    if (exp_q.size() != 0) begin
      last_exp = exp_q.pop_front();
      check("result", obs_pack(), last_exp);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid_low", W'(out_valid), W'(0));
    check("hs_in_ready_high", W'(in_ready), W'(1));
  endtask

  // stimulus
  initial begin
    bit c;
    int len;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    model_clear();
    @(negedge clk);
    apply_reset();

    // basic three-beat frame
    send_beat(lanes4(10, 0, 0, 0), lanes4(5, 0, 0, 0), 1'b0, 1'b0, 0, c);
    send_beat(lanes4(3, 0, 0, 0), lanes4(0, 0, 0, 0), 1'b0, 1'b0, 0, c);
    send_beat(lanes4(7, 0, 0, 0), lanes4(0, 0, 0, 0), 1'b0, 1'b1, 0, c);
    wait_result();
    check("f1_min1_l0", W'(min1_o[7:0]), W'(3));
    check("f1_idx1_l0", W'(idx1_o[3:0]), W'(1));
    check("f1_min2_l0", W'(min2_o[7:0]), W'(7));
    check("f1_deg", W'(deg_o), W'(3));
    check("f1_err", W'(err_o), W'(0));
    handshake();

    // saturation, single-beat frames (add, then subtract)
    send_beat(lanes4(60, -60, 5, -128), lanes4(10, -10, 2, -128), 1'b0, 1'b1, 0, c);
    wait_result();
    check("sat_add_min1", W'(min1_o), W'(lanes4(63, -63, 7, -63)));
    check("sat_add_min2", W'(min2_o), W'(lanes4(63, 63, 63, 63)));
    check("sat_add_idx1", W'(idx1_o), W'(0));
    handshake();
    send_beat(lanes4(60, -60, 5, 100), lanes4(-10, 10, -2, -27), 1'b1, 1'b1, 0, c);
    wait_result();
    check("sat_sub_min1", W'(min1_o), W'(lanes4(63, -63, 7, 63)));
    check("sat_sub_deg", W'(deg_o), W'(1));
    handshake();

    // truncated 16-beat frame, then backpressure on its result
    for (int k = 0; k < 16; k++)
      send_beat(lanes4(20 - k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
                lanes4(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
                1'b0, 1'b0, 0, c);
    check("trunc_closed", W'(c), W'(1));
    wait_result();
    check("trunc_min1_l0", W'(min1_o[7:0]), W'(5));
    check("trunc_idx1_l0", W'(idx1_o[3:0]), W'(15));
    check("trunc_min2_l0", W'(min2_o[7:0]), W'(6));
    check("trunc_deg", W'(deg_o), W'(16));
    check("trunc_err", W'(err_o), W'(1));
    in_a = lanes4(1, 1, 1, 1); in_b = '0; in_sub = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_stable", obs_pack(), last_exp);
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_out_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_hs_out_valid", W'(out_valid), W'(0));
    check("bp_hs_no_accept", W'(deg_o), W'(0));

    // 16 beats ending with last on the final index: not an error
    for (int k = 0; k < 16; k++)
      send_beat(lanes4(k, -k, 40, 0), lanes4(0, 0, k, 0), 1'b1, 1'(k == 15), 0, c);
    wait_result();
    check("full_err", W'(err_o), W'(0));
    handshake();

    // ties
    send_beat(lanes4(4, 0, 0, 0), '0, 1'b0, 1'b0, 0, c);
    send_beat(lanes4(4, 0, 0, 0), '0, 1'b0, 1'b0, 1, c);
    send_beat(lanes4(9, 0, 0, 0), '0, 1'b0, 1'b1, 0, c);
    wait_result();
    check("tie_min1", W'(min1_o[7:0]), W'(4));
    check("tie_idx1", W'(idx1_o[3:0]), W'(0));
    check("tie_min2", W'(min2_o[7:0]), W'(4));
    handshake();

    // reset mid-frame, then a clean single-beat frame
    send_beat(lanes4(1, 1, 1, 1), '0, 1'b0, 1'b0, 0, c);
    send_beat(lanes4(2, 2, 2, 2), '0, 1'b0, 1'b0, 0, c);
    apply_reset();
    send_beat(lanes4(8, 8, 8, 8), '0, 1'b0, 1'b1, 0, c);
    wait_result();
    check("rst_frame_min1", W'(min1_o), W'(lanes4(8, 8, 8, 8)));
    check("rst_frame_deg", W'(deg_o), W'(1));
    handshake();

    // reset with a pending result
    send_beat(lanes4(-5, 3, 2, 1), '0, 1'b0, 1'b1, 0, c);
    apply_reset();

    // random frames with idle gaps and random result delay
    repeat (12) begin
      len = $urandom_range(1, 18);
      for (int k = 0; k < len; k++) begin
        send_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'(k == len - 1), $urandom_range(0, 2), c);
        if (c) break;
      end
      wait_result();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
    end

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
